// File: rtl/multi_preview_fifo.sv
// Show-ahead FIFO taking and releasing 0..LANES words per cycle, previewing the oldest LANES words.
// Define MULTI_PREVIEW_FIFO_ERR_EN to add sticky overflow/underflow outputs (ovf, udf).
module multi_preview_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LANES = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [$clog2(LANES+1)-1:0]   wr_cnt,
  input  logic [LANES*WIDTH-1:0]       id,
  input  logic [$clog2(LANES+1)-1:0]   rd_cnt,
  output logic [LANES*WIDTH-1:0]       od,
  output logic [LANES-1:0]             empty,
  output logic [LANES-1:0]             full,
  output logic [$clog2(DEPTH+1)-1:0]   usedw,
  output logic                         wr_ack,
`ifdef MULTI_PREVIEW_FIFO_ERR_EN
  output logic                         ovf,
  output logic                         udf,
`endif
  output logic                         rd_ack
);

  localparam int unsigned CntW  = $clog2(LANES + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned UsedW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [UsedW-1:0] usedw_q, usedw_d;
  logic [UsedW-1:0] space;
  logic             wr_ack_q, rd_ack_q;
  logic             wr_acc, rd_acc;

  // Acceptance uses start-of-cycle occupancy only; same-cycle traffic in the other direction
  // neither frees space nor provides data.
  assign space  = UsedW'(DEPTH) - usedw_q;
  assign wr_acc = (wr_cnt != '0) && (wr_cnt <= CntW'(LANES)) && (UsedW'(wr_cnt) <= space);
  assign rd_acc = (rd_cnt != '0) && (rd_cnt <= CntW'(LANES)) && (UsedW'(rd_cnt) <= usedw_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PtrW'(wr_cnt);
      usedw_d  = usedw_d + UsedW'(wr_cnt);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PtrW'(rd_cnt);
      usedw_d  = usedw_d - UsedW'(rd_cnt);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      wr_ack_q <= wr_acc;
      rd_ack_q <= rd_acc;
    end
  end

  // Storage is deliberately left unreset; the preview masks lanes beyond occupancy.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wr_acc && (CntW'(k) < wr_cnt)) begin
        mem_q[wr_ptr_q + PtrW'(k)] <= id[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    od    = '0;
    empty = '0;
    full  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (UsedW'(k) < usedw_q) begin
        od[k*WIDTH +: WIDTH] = mem_q[rd_ptr_q + PtrW'(k)];
      end
      empty[k] = (usedw_q <= UsedW'(k));
      full[k]  = (space <= UsedW'(k));
    end
  end

  assign usedw  = usedw_q;
  assign wr_ack = wr_ack_q;
  assign rd_ack = rd_ack_q;

`ifdef MULTI_PREVIEW_FIFO_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (!wr_acc && (wr_cnt != '0)) ovf_q <= 1'b1;
      if (!rd_acc && (rd_cnt != '0)) udf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_multi_preview_fifo.sv
// Self-checking bench for multi_preview_fifo: queue-based reference model plus directed literals.
module tb_multi_preview_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LANES = 4;

  logic        clk;
  logic        nrst;
  logic [2:0]  wr_cnt;
  logic [31:0] id;
  logic [2:0]  rd_cnt;
  logic [31:0] od;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [5:0]  usedw;
  logic        wr_ack;
  logic        rd_ack;
`ifdef MULTI_PREVIEW_FIFO_ERR_EN
  logic        ovf;
  logic        udf;
`endif

  multi_preview_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LANES(LANES)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .wr_cnt(wr_cnt),
    .id    (id),
    .rd_cnt(rd_cnt),
    .od    (od),
    .empty (empty),
    .full  (full),
    .usedw (usedw),
    .wr_ack(wr_ack),
`ifdef MULTI_PREVIEW_FIFO_ERR_EN
    .ovf   (ovf),
    .udf   (udf),
`endif
    .rd_ack(rd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO contents as a plain queue, oldest at the front.
  logic [7:0] q[$];
  bit m_wr_ack, m_rd_ack, m_ovf, m_udf;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q.delete();
      m_wr_ack <= 1'b0;
      m_rd_ack <= 1'b0;
      m_ovf    <= 1'b0;
      m_udf    <= 1'b0;
    end else begin
      int  n;
      bit  wa, ra;
      n  = q.size();
      wa = (wr_cnt != 0) && (int'(wr_cnt) <= LANES) && (int'(wr_cnt) <= DEPTH - n);
      ra = (rd_cnt != 0) && (int'(rd_cnt) <= LANES) && (int'(rd_cnt) <= n);
      if (ra) for (int i = 0; i < int'(rd_cnt); i++) void'(q.pop_front());
      if (wa) for (int i = 0; i < int'(wr_cnt); i++) q.push_back(id[i*8 +: 8]);
      m_wr_ack <= wa;
      m_rd_ack <= ra;
      if (!wa && wr_cnt != 0) m_ovf <= 1'b1;
      if (!ra && rd_cnt != 0) m_udf <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] e_od;
      logic [3:0]  e_empty, e_full;
      e_od = '0;
      for (int k = 0; k < int'(LANES); k++) begin
        if (k < q.size()) e_od[k*8 +: 8] = q[k];
        e_empty[k] = (q.size() <= k);
        e_full[k]  = (DEPTH - q.size() <= k);
      end
      check("m_usedw", 64'(usedw), 64'(q.size()));
      check("m_od", 64'(od), 64'(e_od));
      check("m_empty", 64'(empty), 64'(e_empty));
      check("m_full", 64'(full), 64'(e_full));
      check("m_wr_ack", 64'(wr_ack), 64'(m_wr_ack));
      check("m_rd_ack", 64'(rd_ack), 64'(m_rd_ack));
`ifdef MULTI_PREVIEW_FIFO_ERR_EN
      check("m_ovf", 64'(ovf), 64'(m_ovf));
      check("m_udf", 64'(udf), 64'(m_udf));
`endif
    end
  end

  // Drive one request over a rising edge; return #1 after it with inputs idle.
  task automatic cyc(input int wc, input logic [31:0] wd, input int rc);
    wr_cnt = 3'(wc);
    id     = wd;
    rd_cnt = 3'(rc);
    @(posedge clk);
    #1;
    wr_cnt = '0;
    rd_cnt = '0;
    id     = '0;
  endtask

  initial begin
    nrst   = 1'b0;
    wr_cnt = '0;
    rd_cnt = '0;
    id     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst   = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("rst_usedw", 64'(usedw), 64'd0);
    check("rst_empty", 64'(empty), 64'hF);
    check("rst_full", 64'(full), 64'h0);
    check("rst_od", 64'(od), 64'h0);

    // Basic write, then simultaneous read and write.
    cyc(3, 32'h0003_0201, 0);
    check("t1_usedw", 64'(usedw), 64'd3);
    check("t1_od", 64'(od), 64'h0003_0201);
    check("t1_empty", 64'(empty), 64'b1000);
    check("t1_wr_ack", 64'(wr_ack), 64'd1);
    cyc(4, 32'h0706_0504, 2);
    check("t2_usedw", 64'(usedw), 64'd5);
    check("t2_od", 64'(od), 64'h0605_0403);
    check("t2_rd_ack", 64'(rd_ack), 64'd1);
    check("t2_wr_ack", 64'(wr_ack), 64'd1);

    // Fill 5 -> 30, overflow attempt, then top off.
    repeat (6) cyc(4, $urandom, 0);
    cyc(1, $urandom, 0);
    check("t3_fill", 64'(usedw), 64'd30);
    cyc(3, $urandom, 0);
    check("t3_wr_ack", 64'(wr_ack), 64'd0);
    check("t3_usedw", 64'(usedw), 64'd30);
    check("t3_full", 64'(full), 64'b1100);
`ifdef MULTI_PREVIEW_FIFO_ERR_EN
    check("t3_ovf", 64'(ovf), 64'd1);
`endif
    cyc(2, $urandom, 0);
    check("t3_usedw32", 64'(usedw), 64'd32);
    check("t3_full32", 64'(full), 64'hF);

    // Drain 32 -> 1, underflow attempt, then empty.
    repeat (7) cyc(0, '0, 4);
    cyc(0, '0, 3);
    check("t4_drain", 64'(usedw), 64'd1);
    cyc(0, '0, 2);
    check("t4_rd_ack", 64'(rd_ack), 64'd0);
    check("t4_usedw", 64'(usedw), 64'd1);
`ifdef MULTI_PREVIEW_FIFO_ERR_EN
    check("t4_udf", 64'(udf), 64'd1);
`endif
    cyc(0, '0, 1);
    check("t4_usedw0", 64'(usedw), 64'd0);
    check("t4_od0", 64'(od), 64'h0);

    // 34 words written so far leaves both pointers at 2; move 28 more words through to reach 30.
    repeat (7) cyc(4, $urandom, 0);
    repeat (7) cyc(0, '0, 4);
    cyc(4, 32'hA3A2_A1A0, 0);
    check("t5_od", 64'(od), 64'hA3A2_A1A0);
    check("t5_usedw", 64'(usedw), 64'd4);
    cyc(0, '0, 4);
    check("t5_rd_ack", 64'(rd_ack), 64'd1);
    check("t5_usedw0", 64'(usedw), 64'd0);

    // Randomized traffic including illegal counts.
    for (int i = 0; i < 3000; i++) begin
      int wc, rc;
      wc = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      rc = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      cyc(wc, $urandom, rc);
    end

    // Asynchronous reset in the middle of a write cycle.
    repeat (3) cyc(4, $urandom, 0);
    wr_cnt = 3'd4;
    id     = $urandom;
    #2;
    nrst = 1'b0;
    #1;
    check("t6_usedw", 64'(usedw), 64'd0);
    check("t6_od", 64'(od), 64'h0);
    check("t6_empty", 64'(empty), 64'hF);
    check("t6_wr_ack", 64'(wr_ack), 64'd0);
    @(posedge clk);
    #1;
    wr_cnt = '0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) cyc(2, $urandom, 1);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
